ibuf_offset_cal: RTL and testbench

//  Offset-calibration sequencer for one differential input buffer with offset-cancellation

---
 rtl/ibuf_offset_cal.sv | 126 ++++++++++++
 tb/tb_ibuf_offset_cal.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/ibuf_offset_cal.sv
// ibuf_offset_cal: offset-calibration sequencer for one differential input buffer.
//   Sweeps the sign-magnitude offset code -7..+7 and latches the first code whose synchronised
//   buffer output is majority-high over SAMPLE_CYCLES samples.
//   Ports: clk, rst_n (async active-low), start, o_buf (async) -> osc, osc_en, busy, done,
//   fail, cal_code. Optional IBUF_OFFSET_CAL_HIST_EN adds hist_addr/hist_data, a per-code
//   ones-count readback with one cycle of read latency.
module ibuf_offset_cal #(
  parameter int SETTLE_CYCLES = 16,
  parameter int SAMPLE_CYCLES = 32,
  localparam int OW = $clog2(SAMPLE_CYCLES + 1),
  localparam int CMAX = SETTLE_CYCLES > SAMPLE_CYCLES ? SETTLE_CYCLES : SAMPLE_CYCLES,
  localparam int CW = $clog2(CMAX)
) (
`ifdef IBUF_OFFSET_CAL_HIST_EN
  input  logic [3:0]    hist_addr,
  output logic [OW-1:0] hist_data,
`endif
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          o_buf,
  output logic [3:0]    osc,
  output logic [1:0]    osc_en,
  output logic          busy,
  output logic          done,
  output logic          fail,
  output logic [3:0]    cal_code
);
  typedef enum logic [2:0] {IDLE, SETTLE, SAMPLE, EVAL, DONE} state_t;
  state_t state, state_nx;
  logic s1, s2;
  logic [CW-1:0] cnt;
  logic [OW-1:0] ones;
  logic signed [3:0] code;
  logic high, settle_end, sample_end, finish;

  function automatic logic [3:0] enc(input logic signed [3:0] c);
    logic [3:0] m;
    m = c[3] ? -c : c;
    return {~c[3], m[2:0]};
  endfunction

  always_comb begin
    high = ones >= OW'(SAMPLE_CYCLES / 2);
    settle_end = cnt == CW'(SETTLE_CYCLES - 1);
    sample_end = cnt == CW'(SAMPLE_CYCLES - 1);
    finish = high || code == 4'sd7;
    state_nx = state;
    case (state)
      IDLE:    state_nx = start ? SETTLE : IDLE;
      SETTLE:  state_nx = settle_end ? SAMPLE : SETTLE;
      SAMPLE:  state_nx = sample_end ? EVAL : SAMPLE;
      EVAL:    state_nx = finish ? DONE : SETTLE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      s1 <= 1'b0;
      s2 <= 1'b0;
      cnt <= '0;
      ones <= '0;
      code <= '0;
      osc <= 4'b1000;
      osc_en <= 2'b00;
      busy <= 1'b0;
      done <= 1'b0;
      fail <= 1'b0;
      cal_code <= 4'b1000;
    end else begin
      state <= state_nx;
      s1 <= o_buf;
      s2 <= s1;
      done <= 1'b0;
      cnt <= ((state == SETTLE && !settle_end) || (state == SAMPLE && !sample_end)) ? cnt + 1'b1 : '0;
      if (state == SAMPLE) ones <= ones + OW'(s2);
      case (state)
        IDLE: if (start) begin
          code <= -4'sd7;
          osc <= enc(-4'sd7);
          osc_en <= 2'b11;
          busy <= 1'b1;
          fail <= 1'b0;
        end
        EVAL: begin
          ones <= '0;
          if (finish) begin
            // Fail when already high at -7 (never low) or never high by +7.
            fail <= !high || code == -4'sd7;
            cal_code <= enc(code);
          end else begin
            code <= code + 4'sd1;
            osc <= enc(code + 4'sd1);
          end
        end
        DONE: begin
          done <= 1'b1;
          busy <= 1'b0;
          osc_en <= 2'b00;
          osc <= cal_code;
        end
        default: ;
      endcase
    end
  end

`ifdef IBUF_OFFSET_CAL_HIST_EN
  logic [OW-1:0] hist [15];
  logic [3:0] hidx;
  assign hidx = code + 4'sd7;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 15; i++) hist[i] <= '0;
      hist_data <= '0;
    end else begin
      if (state == IDLE && start) for (int i = 0; i < 15; i++) hist[i] <= '0;
      else if (state == EVAL) hist[hidx] <= ones;
      hist_data <= (hist_addr == 4'hf) ? '0 : hist[hist_addr];
    end
  end
`endif
endmodule

// File: tb/tb_ibuf_offset_cal.sv
// tb_ibuf_offset_cal: randomized self-checking bench for ibuf_offset_cal against a
//   per-code high-count buffer model and a first-majority-code reference.
module tb_ibuf_offset_cal;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, o_buf = 1'b0;
  logic [3:0] osc, cal_code;
  logic [1:0] osc_en;
  logic busy, done, fail;
`ifdef IBUF_OFFSET_CAL_HIST_EN
  logic [3:0] hist_addr = 4'd0;
  logic [5:0] hist_data;
`endif
  int errors = 0, checks = 0, cyc = 0, rel = 0;
  int bad_en = 0, bad_osc = 0, bad_stab = 0;
  int k_tab [15];
  int cur, kk;
  logic [3:0] prev_osc = 4'b1000;
  logic prev_busy = 1'b0;

  always #5 clk = ~clk;

  ibuf_offset_cal dut (
`ifdef IBUF_OFFSET_CAL_HIST_EN
    .hist_addr(hist_addr),
    .hist_data(hist_data),
`endif
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .o_buf(o_buf),
    .osc(osc),
    .osc_en(osc_en),
    .busy(busy),
    .done(done),
    .fail(fail),
    .cal_code(cal_code)
  );

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int dec(input logic [3:0] o);
    return o[3] ? int'(o[2:0]) : -int'(o[2:0]);
  endfunction

  function automatic logic [3:0] enc(input int c);
    logic [2:0] m;
    m = 3'(c < 0 ? -c : c);
    return {c >= 0, m};
  endfunction

  task automatic check(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Buffer model: per code, o_buf is high for k_tab cycles inside the sampling window
  // (32 = always high, 0 = always low). Also watches the output legality rules.
  always @(negedge clk) begin
    if (osc !== prev_osc || (busy && !prev_busy)) begin
      if (osc !== prev_osc && busy && prev_busy && rel != 48) bad_stab++;
      rel = 0;
    end else rel++;
    if (osc_en == 2'b01 || osc_en == 2'b10) bad_en++;
    if (osc == 4'b0000) bad_osc++;
    cur = dec(osc);
    kk = k_tab[cur + 7];
    o_buf = kk >= 32 ? 1'b1 : kk == 0 ? 1'b0 : (rel >= 18 && rel < 18 + kk);
    prev_osc = osc;
    prev_busy = busy;
  end

  task automatic set_offset(input int off);
    for (int c = -7; c <= 7; c++) k_tab[c + 7] = (off + 5 * c > 0) ? 32 : 0;
  endtask

  task automatic run_cal(input string name, input bit extra_start);
    int n, code, f, s, t;
    n = 15; code = 7; f = 1;
    for (int c = -7; c <= 7; c++)
      if (k_tab[c + 7] >= 16) begin
        n = c + 8; code = c; f = (c == -7);
        break;
      end
    @(negedge clk);
    start = 1'b1;
    s = cyc;
    @(negedge clk);
    start = 1'b0;
    check({name, " busy"}, busy, 1);
    check({name, " osc_en_cal"}, osc_en, 3);
    t = 0;
    while (!done && t < 1000) begin
      @(negedge clk);
      t++;
      start = (extra_start && t == 100);
    end
    start = 1'b0;
    check({name, " done"}, done, 1);
    check({name, " latency"}, cyc - s, n * 49 + 2);
    check({name, " cal_code"}, cal_code, enc(code));
    check({name, " fail"}, fail, f);
    check({name, " busy_end"}, busy, 0);
    check({name, " osc_end"}, osc, enc(code));
    check({name, " osc_en_end"}, osc_en, 0);
`ifdef IBUF_OFFSET_CAL_HIST_EN
    for (int i = 0; i < 16; i++) begin
      hist_addr = 4'(i);
      @(negedge clk);
      check({name, " hist"}, hist_data, (i < n) ? k_tab[i] : 0);
    end
`else
    @(negedge clk);
`endif
    check({name, " done_pulse"}, done, 0);
  endtask

  initial begin
    set_offset(10);
    repeat (3) @(negedge clk);
    check("rst osc", osc, 4'b1000);
    check("rst osc_en", osc_en, 0);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst fail", fail, 0);
    check("rst cal_code", cal_code, 4'b1000);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    run_cal("off+10", 1'b0);
    set_offset(-50);
    run_cal("off-50", 1'b0);
    set_offset(50);
    run_cal("off+50", 1'b0);
    for (int c = 0; c < 15; c++) k_tab[c] = 0;
    k_tab[9] = 16;
    k_tab[8] = 15;
    run_cal("thr16", 1'b0);
    for (int c = 0; c < 15; c++) k_tab[c] = 15;
    run_cal("thr15", 1'b0);
    set_offset(10);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4 * 49 + 29) @(negedge clk);
    check("mid osc", osc, enc(-3));
    rst_n = 1'b0;
    #1;
    check("mid rst osc_en", osc_en, 0);
    check("mid rst osc", osc, 4'b1000);
    check("mid rst busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    run_cal("after_rst", 1'b0);
    run_cal("restart", 1'b1);
    for (int r = 0; r < 6; r++) begin
      for (int c = 0; c < 15; c++)
        case ($urandom_range(0, 3))
          0: k_tab[c] = 0;
          1: k_tab[c] = 32;
          default: k_tab[c] = $urandom_range(0, 24);
        endcase
      run_cal("rand", 1'b0);
    end
    check("osc_en legal", bad_en, 0);
    check("osc nonzero", bad_osc, 0);
    check("osc stable", bad_stab, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
